pmem_responder: RTL and testbench



---
 rtl/pmem_types_pkg.sv | 15 +
 rtl/pmem_line_array.sv | 31 +++
 rtl/pmem_responder.sv | 140 ++++++++++++++
 tb/tb_pmem_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pmem_types_pkg.sv
// rtl/pmem_types_pkg.sv - shared line width, line type and FSM state encoding for the pmem responder
package pmem_types;

    localparam int PMEM_LINE_W   = 256;
    localparam int PMEM_OFFSET_W = 5;

    typedef logic [PMEM_LINE_W-1:0] pmem_line_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } pmem_state_t;

endpackage

// File: rtl/pmem_line_array.sv
// rtl/pmem_line_array.sv - DEPTH x 256-bit line storage, one-cycle synchronous read, synchronous write, no reset
module pmem_line_array
    import pmem_types::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rd_en_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  pmem_line_t       wdata_i,
    output pmem_line_t       rdata_o
);

    pmem_line_t mem_q [DEPTH];
    pmem_line_t rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wr_idx_i] <= wdata_i;
        end
        if (rd_en_i) begin
            rdata_q <= mem_q[rd_idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pmem_responder.sv
// rtl/pmem_responder.sv - memory end of the cache line protocol; optional PMEM_STATS_EN adds rd/wr counters
module pmem_responder
    import pmem_types::*;
#(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 256,
    parameter int IDX_W   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [31:0]  pmem_address,
    input  logic [255:0] pmem_wdata,
    output logic         pmem_resp,
    output logic [255:0] pmem_rdata,
    output logic         pmem_err
`ifdef PMEM_STATS_EN
    ,
    output logic [31:0]  rd_count,
    output logic [31:0]  wr_count
`endif
);

    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    pmem_state_t state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        op_wr_q, op_wr_d;
    logic        err_q, err_d;
    logic        resp_q;
    pmem_line_t  rdata_q;
    logic        rd_go;
    logic        active_req;
    logic        opposite_req;
    pmem_line_t  arr_rdata;
    logic [IDX_W-1:0] idx;
    logic        unused_addr;

    assign idx         = pmem_address[PMEM_OFFSET_W +: IDX_W];
    assign unused_addr = ^pmem_address;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_wr_d      = op_wr_q;
        err_d        = err_q;
        rd_go        = 1'b0;
        active_req   = op_wr_q ? pmem_write : pmem_read;
        opposite_req = op_wr_q ? pmem_read  : pmem_write;
        case (state_q)
            IDLE: begin
                if (pmem_read && pmem_write) begin
                    err_d = 1'b1;
                end else if (pmem_read || pmem_write) begin
                    op_wr_d = pmem_write;
                    cnt_d   = LAT_M1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        rd_go   = !pmem_write;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                // An abort takes precedence even on the last countdown cycle.
                if (!active_req || opposite_req) begin
                    state_d = IDLE;
                end else if (cnt_q == 8'd1) begin
                    state_d = RESP;
                    rd_go   = !op_wr_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            err_q   <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            err_q   <= err_d;
            resp_q  <= (state_d == RESP);
            if (state_q == RESP && !op_wr_q) begin
                rdata_q <= arr_rdata;
            end
        end
    end

    pmem_line_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_lines (
        .clk_i    (clk),
        .rd_en_i  (rd_go),
        .rd_idx_i (idx),
        .we_i     (state_q == RESP && op_wr_q),
        .wr_idx_i (idx),
        .wdata_i  (pmem_wdata),
        .rdata_o  (arr_rdata)
    );

    // The array's read register carries the line during the resp cycle; rdata_q holds it afterwards.
    assign pmem_rdata = (state_q == RESP && !op_wr_q) ? arr_rdata : rdata_q;
    assign pmem_resp  = resp_q;
    assign pmem_err   = err_q;

`ifdef PMEM_STATS_EN
    logic [31:0] rd_count_q, wr_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else if (state_q == RESP) begin
            if (op_wr_q) begin
                wr_count_q <= wr_count_q + 32'd1;
            end else begin
                rd_count_q <= rd_count_q + 32'd1;
            end
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// tb/tb_pmem_responder.sv - self-checking bench for pmem_responder against a line-level memory model
module tb_pmem_responder;

    localparam int LAT   = 4;
    localparam int DEPTH = 256;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd, wr, rd1, wr1;
    logic [31:0]  addr, addr1;
    logic [255:0] wdata, wdata1;
    wire          resp, resp1, err, err1;
    wire  [255:0] rdata, rdata1;
`ifdef PMEM_STATS_EN
    wire  [31:0]  rd_count, wr_count, rd_count1, wr_count1;
`endif

    always #5 clk = ~clk;

    pmem_responder #(.LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pmem_read(rd), .pmem_write(wr), .pmem_address(addr),
        .pmem_wdata(wdata), .pmem_resp(resp), .pmem_rdata(rdata), .pmem_err(err)
`ifdef PMEM_STATS_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    pmem_responder #(.LATENCY(1), .DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst(rst), .pmem_read(rd1), .pmem_write(wr1), .pmem_address(addr1),
        .pmem_wdata(wdata1), .pmem_resp(resp1), .pmem_rdata(rdata1), .pmem_err(err1)
`ifdef PMEM_STATS_EN
        , .rd_count(rd_count1), .wr_count(wr_count1)
`endif
    );

    int           checks = 0;
    int           errors = 0;
    logic [255:0] model_mem [DEPTH];
    bit           model_vld [DEPTH];
    logic [255:0] last_rd = '0;
    int           exp_rd = 0, exp_wr = 0;
    logic [31:0]  written_q [$];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 5) % DEPTH);
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic do_op(input bit is_wr, input logic [31:0] a, input logic [255:0] d, input string tag);
        int first = -1;
        int n = 0;
        logic [255:0] got = '0;
        int li = line_of(a);
        @(posedge clk); #1;
        addr = a; wdata = d; rd = !is_wr; wr = is_wr;
        for (int c = 0; c < LAT + 4; c++) begin
            @(negedge clk);
            if (resp === 1'b1) begin
                n++;
                if (first < 0) begin
                    first = c;
                    got = rdata;
                end
            end
            @(posedge clk); #1;
            if (first >= 0) begin
                rd = 1'b0; wr = 1'b0;
            end
        end
        rd = 1'b0; wr = 1'b0;
        check({tag, " latency"}, first, LAT);
        check({tag, " resp count"}, n, 1);
        if (is_wr) begin
            model_mem[li] = d;
            model_vld[li] = 1'b1;
            written_q.push_back(a);
            exp_wr++;
            check({tag, " rdata hold"}, rdata, last_rd);
        end else begin
            exp_rd++;
            if (model_vld[li]) begin
                check({tag, " rdata"}, got, model_mem[li]);
                last_rd = model_mem[li];
            end
        end
    endtask

    task automatic quiet_window(input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (resp === 1'b1) n++;
        end
    endtask

    initial begin
        int n;
        logic [31:0] a;
        rst = 1'b1;
        rd = 0; wr = 0; addr = '0; wdata = '0;
        rd1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;
        for (int i = 0; i < DEPTH; i++) model_vld[i] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset resp", resp, 0);
        check("reset rdata", rdata, '0);
        check("reset err", err, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_op(1'b1, 32'h0000_0040, {32{8'hA5}}, "wr 0x40");
        do_op(1'b0, 32'h0000_0040, '0, "rd 0x40");
        do_op(1'b1, 32'h0000_2000, {64{4'h1}}, "wr 0x2000");
        do_op(1'b0, 32'h0000_0000, '0, "rd wrap 0x0");

        do_op(1'b1, 32'h0000_0080, {32{8'hC3}}, "wr 0x80 old");
        @(posedge clk); #1;
        addr = 32'h0000_0080; wdata = {256{1'b1}}; wr = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        wr = 1'b0;
        quiet_window(LAT + 3, n);
        check("abort no resp", n, 0);
        do_op(1'b0, 32'h0000_0080, '0, "rd after abort");
`ifdef PMEM_STATS_EN
        check("stats wr after abort", wr_count, exp_wr);
        check("stats rd after abort", rd_count, exp_rd);
`endif

        for (int i = 0; i < 40; i++) begin
            if (written_q.size() == 0 || $urandom_range(1, 0) == 1) begin
                do_op(1'b1, $urandom(), rand_line(), $sformatf("rand wr %0d", i));
            end else begin
                a = written_q[$urandom_range(written_q.size() - 1, 0)];
                a = {$urandom_range(255, 0) ^ a[31:24], a[23:13], a[12:5], 5'($urandom())};
                do_op(1'b0, a, '0, $sformatf("rand rd %0d", i));
            end
        end

        @(posedge clk); #1;
        addr = 32'h0000_0100; rd = 1'b1; wr = 1'b1;
        quiet_window(3, n);
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
        quiet_window(LAT + 2, n);
        check("both req no resp", n, 0);
        check("err set", err, 1);
        do_op(1'b0, 32'h0000_0040, '0, "rd after err");
        check("err sticky", err, 1);

        @(posedge clk); #1;
        addr = 32'h0000_0040; wdata = {8{32'hDEAD_BEEF}}; wr = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        wr = 1'b0;
        #1;
        check("rst rdata", rdata, '0);
        check("rst err", err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        quiet_window(LAT + 3, n);
        check("rst no resp", n, 0);
        last_rd = '0;
        exp_rd = 0;
        exp_wr = 0;
        do_op(1'b0, 32'h0000_0040, '0, "rd after rst");
`ifdef PMEM_STATS_EN
        check("stats wr after rst", wr_count, exp_wr);
        check("stats rd after rst", rd_count, exp_rd);
`endif

        @(posedge clk); #1;
        addr1 = 32'h0; rd1 = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check($sformatf("lat1 resp c%0d", c), resp1, (c == 1 || c == 3));
            @(posedge clk); #1;
            if (c == 3) rd1 = 1'b0;
        end
        check("lat1 err", err1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
